// File: rtl/carrier_nco.sv
// carrier_nco: carrier NCO producing 3-bit cos/sin samples with epoch-aligned frequency correction
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   ce              sample enable, NCO advances only when high
//   corr_in         17-bit signed frequency correction from the loop filter
//   corr_valid      correction offered
//   corr_ready      one-deep correction slot is free
//   cos_out/sin_out quantized carrier samples (-2..2)
//   out_valid       samples updated this cycle
//   epoch           pulse on the last sample of each epoch
// Optional: define CARRIER_NCO_DITHER_EN to add LFSR phase dither ahead of the LUT.
module carrier_nco #(
  parameter int ACC_W = 32,
  parameter logic [ACC_W-1:0] FCW_NOM = 'h4000_0000,
  parameter int CORR_SHIFT = 8,
  parameter int EPOCH_LEN = 16368
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic signed [16:0] corr_in,
  input  logic              corr_valid,
  output logic              corr_ready,
  output logic signed [2:0] cos_out,
  output logic signed [2:0] sin_out,
  output logic              out_valid,
  output logic              epoch
);
  localparam int EP_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam logic [23:0] COS_LUT = 24'b010_001_111_110_110_111_001_010;
  localparam logic [23:0] SIN_LUT = 24'b111_110_110_111_001_010_010_001;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_fcw_act;
  logic [16:0]      r_pend;
  logic             r_pend_full;
  logic [EP_W-1:0]  r_ep_cnt;
  logic [2:0]       w_bin;
  logic [4:0]       w_lut_idx;
  logic             w_bound;
  logic [ACC_W-1:0] w_fcw_eff;
  assign corr_ready = !r_pend_full;
  assign w_bound    = ce && (r_ep_cnt == EP_W'(EPOCH_LEN - 1));
  // Correction is sign-extended before shifting; the sum wraps modulo 2^ACC_W.
  assign w_fcw_eff  = FCW_NOM + (ACC_W'($signed(r_pend)) << CORR_SHIFT);
  assign w_lut_idx  = 5'(w_bin) * 5'd3;
`ifdef CARRIER_NCO_DITHER_EN
  logic [15:0]      r_lfsr;
  logic [ACC_W-1:0] w_dith;
  // Dither stays below one bin; only the LUT address sees it, never acc.
  assign w_dith = r_acc + (ACC_W'(r_lfsr[7:0]) << (ACC_W - 11));
  assign w_bin  = w_dith[ACC_W-1 -: 3];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 16'hACE1;
    else if (ce) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
`else
  assign w_bin = r_acc[ACC_W-1 -: 3];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_fcw_act   <= FCW_NOM;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_ep_cnt    <= '0;
      cos_out     <= '0;
      sin_out     <= '0;
      out_valid   <= 1'b0;
      epoch       <= 1'b0;
    end else begin
      // A full slot at the boundary is drained; an offer on that edge is refused
      // because accept only happens while the slot is empty.
      if (w_bound && r_pend_full) begin
        r_fcw_act   <= w_fcw_eff;
        r_pend_full <= 1'b0;
      end else if (corr_valid && !r_pend_full) begin
        r_pend      <= corr_in;
        r_pend_full <= 1'b1;
      end
      out_valid <= ce;
      epoch     <= w_bound;
      if (ce) begin
        r_acc    <= r_acc + r_fcw_act;
        cos_out  <= COS_LUT[w_lut_idx +: 3];
        sin_out  <= SIN_LUT[w_lut_idx +: 3];
        r_ep_cnt <= w_bound ? '0 : r_ep_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_carrier_nco.sv
// tb_carrier_nco: directed checks of carrier_nco with a 16-sample epoch
module tb_carrier_nco;
  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic signed [16:0] corr_in;
  logic              corr_valid;
  logic              corr_ready;
  logic signed [2:0] cos_out;
  logic signed [2:0] sin_out;
  logic              out_valid;
  logic              epoch;
  int                n_cmp = 0;
  int                n_err = 0;
  int                ec[4] = '{2, -1, -2, 1};
  int                es[4] = '{1, 2, -1, -2};

  carrier_nco #(.EPOCH_LEN(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .corr_in(corr_in), .corr_valid(corr_valid),
    .corr_ready(corr_ready), .cos_out(cos_out), .sin_out(sin_out),
    .out_valid(out_valid), .epoch(epoch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic step(input logic c);
    ce = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; corr_valid = 1'b0; corr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cos", cos_out, 0);
    chk("rst_sin", sin_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_ready", corr_ready, 1);
    rst = 1'b0;
    // nominal tone, ce held high; 16th sample closes the epoch
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("tone_cos", cos_out, ec[i % 4]);
      chk("tone_sin", sin_out, es[i % 4]);
      chk("tone_ov", out_valid, 1);
      chk("tone_epoch", epoch, (i == 15) ? 1 : 0);
    end
    // ce every other cycle: two epochs over 64 clocks, outputs hold while ce=0
    for (int n = 1; n <= 32; n++) begin
      step(1);
      chk("gate_ov_hi", out_valid, 1);
      chk("gate_epoch_hi", epoch, (n % 16 == 0) ? 1 : 0);
      chk("gate_cos_hi", cos_out, ec[(n - 1) % 4]);
      step(0);
      chk("gate_ov_lo", out_valid, 0);
      chk("gate_epoch_lo", epoch, 0);
      chk("gate_cos_lo", cos_out, ec[(n - 1) % 4]);
    end
    // +1 correction accepted on ce count 5, applied at the epoch boundary
    for (int n = 1; n <= 16; n++) begin
      if (n == 5) begin corr_valid = 1'b1; corr_in = 17'sd1; end
      step(1);
      corr_valid = 1'b0;
      chk("hs_ready", corr_ready, (n >= 5 && n < 16) ? 0 : 1);
      chk("hs_epoch", epoch, (n == 16) ? 1 : 0);
    end
    chk("hs_fcw", dut.r_fcw_act, 32'h4000_0100);
    chk("hs_acc0", dut.r_acc, 32'h0000_0000);
    step(1);
    chk("hs_acc1", dut.r_acc, 32'h4000_0100);
    step(1);
    chk("hs_acc2", dut.r_acc, 32'h8000_0200);
    // -65536 offered on the boundary edge with the slot empty
    for (int n = 3; n <= 16; n++) begin
      if (n == 16) begin corr_valid = 1'b1; corr_in = 17'h10000; end
      step(1);
      corr_valid = 1'b0;
    end
    chk("neg_epoch", epoch, 1);
    chk("neg_ready", corr_ready, 0);
    chk("neg_fcw_old", dut.r_fcw_act, 32'h4000_0100);
    chk("neg_acc_b", dut.r_acc, 32'h0000_1000);
    // next boundary applies it; a value offered on that edge is refused
    for (int n = 1; n <= 16; n++) begin
      if (n == 16) begin corr_valid = 1'b1; corr_in = 17'sd5; end
      step(1);
      corr_valid = 1'b0;
      chk("neg_ready_w", corr_ready, (n == 16) ? 1 : 0);
    end
    chk("neg_epoch2", epoch, 1);
    chk("neg_fcw_new", dut.r_fcw_act, 32'h3F00_0000);
    chk("neg_pend_kept", dut.r_pend, 32'sh0001_0000);
    chk("neg_acc_c", dut.r_acc, 32'h0000_2000);
    step(1);
    chk("neg_acc_d", dut.r_acc, 32'h3F00_2000);
    // reset mid-epoch with a correction pending
    for (int n = 2; n <= 9; n++) begin
      if (n == 3) begin corr_valid = 1'b1; corr_in = 17'sd3; end
      step(1);
      corr_valid = 1'b0;
    end
    chk("mid_pending", corr_ready, 0);
    rst = 1'b1;
    #2;
    chk("mid_ready", corr_ready, 1);
    chk("mid_pend_full", dut.r_pend_full, 0);
    chk("mid_acc", dut.r_acc, 0);
    chk("mid_fcw", dut.r_fcw_act, 32'h4000_0000);
    chk("mid_ov", out_valid, 0);
    chk("mid_cos", cos_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("post_epoch", epoch, (i == 15) ? 1 : 0);
      if (i == 0) begin
        chk("post_cos", cos_out, 2);
        chk("post_sin", sin_out, 1);
      end
    end
    chk("post_fcw", dut.r_fcw_act, 32'h4000_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/carrier_nco.md
# carrier_nco

Carrier numerically controlled oscillator for the GPS tracking channel. Generates quantized cosine/sine local-carrier samples for the Costas loop mixers. Takes the 17-bit signed frequency correction from the Costas loop filter and applies it only at code-epoch boundaries, so each integrate-and-dump period sees a constant carrier frequency. Also emits the epoch strobe that the correlators use for dumping.

## Interface
Parameters:
- ACC_W, 32, phase accumulator width (≥ 16)
- FCW_NOM, 32'h4000_0000, nominal frequency control word (IF/fs · 2^ACC_W)
- CORR_SHIFT, 8, left shift applied to the correction before adding it to FCW_NOM
- EPOCH_LEN, 16368, `ce` cycles per epoch (1 ms at 16.368 MHz)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  sample enable; the NCO advances only when high
- corr_in  in  17 signed  frequency correction from the loop filter
- corr_valid  in  1  correction offered
- corr_ready  out  1  correction slot free; reset value 1
- cos_out  out  3 signed  carrier cosine sample; reset value 0
- sin_out  out  3 signed  carrier sine sample; reset value 0
- out_valid  out  1  cos_out/sin_out updated this cycle; reset value 0
- epoch  out  1  single-cycle pulse on the last sample of an epoch; reset value 0

## Operation
- Internal registers:
  - acc, ACC_W bits, reset 0
  - fcw_act, ACC_W bits, reset FCW_NOM
  - pend, 17 bits, reset 0
  - pend_full, reset 0
  - ep_cnt, counts 0..EPOCH_LEN-1, reset 0
- The correction path is a one-deep slot:
  - Accept on a `corr_valid && corr_ready` edge: `pend <= corr_in`, `pend_full <= 1`.
  - `corr_ready = !pend_full`, driven directly from the register.
- Effective FCW = FCW_NOM + (sign-extend(pend) << CORR_SHIFT), truncated to ACC_W bits. Wraps modulo 2^ACC_W with no saturation.
- Phase bin k = acc[ACC_W-1:ACC_W-3]. LUT for k = 0..7:
  - cos: 2, 1, -1, -2, -2, -1, 1, 2
  - sin: 1, 2, 2, 1, -1, -2, -2, -1
- On an edge with ce=1:
  - acc <= acc + fcw_act
  - cos_out/sin_out <= LUT(bin of acc before the update)
  - out_valid <= 1
  - ep_cnt advances
- On an edge with ce=0: out_valid <= 0, epoch <= 0. acc, ep_cnt and outputs hold.
- Epoch boundary is a ce=1 edge with ep_cnt == EPOCH_LEN-1. On that edge:
  - ep_cnt <= 0 and epoch <= 1.
  - If pend_full: fcw_act <= effective FCW and pend_full <= 0.
  - On every other edge, epoch <= 0.
- Simultaneous events:
  - Accept on a boundary edge with the slot empty: the new value goes into pend and is applied at the next boundary, not this one.
  - Boundary with the slot full: the pending value is applied, and corr_ready rises on the following cycle. A correction offered on that same edge is not accepted.
  - The accumulator update on a boundary edge uses the old fcw_act. The new word takes effect from the next ce.
- Reset mid-operation: all registers return to their reset values immediately. Any pending correction is discarded.

## Timing
- Output latency: 1 clk from a ce edge to out_valid/cos_out/sin_out.
- The first sample after reset is bin 0: cos_out=2, sin_out=1.
- epoch is asserted in the same cycle as the out_valid of the last sample of the epoch.
- Correction-to-effect latency runs from acceptance to the next epoch boundary. Worst case is EPOCH_LEN ce cycles plus 1.
- corr_ready stays low from the cycle after acceptance until the cycle after the boundary that applies the correction.

## Configuration
- CARRIER_NCO_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) is seeded with 16'hACE1 on reset and advances on every ce edge.
  - The bin becomes the top 3 bits of (acc + (lfsr[7:0] << (ACC_W-11))). The dither is less than one bin.
  - acc itself is not modified.
- CARRIER_NCO_DITHER_EN undefined: no LFSR exists and the bin equals acc's top 3 bits exactly.
- All test-plan values below assume the macro is undefined.

## Test plan
1. Reset check: assert rst with ce=1 → cos_out=0, sin_out=0, out_valid=0, epoch=0, corr_ready=1. After release, the first ce gives cos_out=2, sin_out=1.
2. Nominal tone: FCW_NOM=32'h4000_0000, ce held high, no correction → bins 0, 2, 4, 6 repeat. cos_out 2, -1, -2, 1 and sin_out 1, 2, -1, -2, period 4.
3. Epoch and ce gating: EPOCH_LEN=16, ce high every other cycle → epoch pulses once per 16 ce edges (32 clk). No out_valid or epoch in ce=0 cycles.
4. Correction handshake: corr_in=+1 accepted at ce count 5 → corr_ready low until 1 cycle after the epoch. After the boundary, acc increments by 32'h4000_0100 per ce.
5. Negative correction and simultaneous accept: corr_in=-65536 presented on the boundary edge with the slot empty → accepted, not applied at that boundary. It is applied at the next boundary, giving fcw_act=32'h3F00_0000.
6. Reset mid-operation: assert rst with a pending correction at ce count 9 → pend_full=0, corr_ready=1, acc=0, fcw_act=FCW_NOM. The next epoch arrives EPOCH_LEN ce edges after release.
